// File: rtl/weather_pkg.sv
// weather_pkg
// Shared definitions for the weather display controller:
//   - active-low seven-segment glyph patterns ({g,f,e,d,c,b,a})
//   - 4-bit display codes fed to the glyph decoder
//   - digit-select enum (leftmost digit is index 0)
//   - FSM state encoding
//   - saturation limit and sensor error code
//   - double-dabble helper functions
package weather_pkg;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_R     = 7'b0101111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // Display codes beyond the decimal digits 0-9
  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_E     = 4'd11;
  localparam logic [3:0] CODE_R     = 4'd12;
  localparam logic [3:0] CODE_BLANK = 4'd13;

  // Digit positions, left to right; index i drives an_out[3-i]
  typedef enum logic [1:0] {
    DIG_T_TENS = 2'd0,
    DIG_T_ONES = 2'd1,
    DIG_H_TENS = 2'd2,
    DIG_H_ONES = 2'd3
  } digit_sel_e;

  // Conversion FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam logic [7:0] SAT_MAX  = 8'd99;
  localparam logic [7:0] ERR_CODE = 8'hFF;

  // Clamp readings above 99 to 99; the error code passes through untouched
  function automatic logic [7:0] saturate(input logic [7:0] value);
    logic [7:0] result;
    if ((value != ERR_CODE) && (value > SAT_MAX)) begin
      result = SAT_MAX;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // Add-3 correction applied to a BCD nibble before each shift
  function automatic logic [3:0] bcd_adjust(input logic [3:0] nibble);
    logic [3:0] result;
    if (nibble >= 4'd5) begin
      result = nibble + 4'd3;
    end else begin
      result = nibble;
    end
    return result;
  endfunction

  // One double-dabble iteration on {tens, ones, binary}
  function automatic logic [15:0] dd_step(input logic [15:0] acc);
    logic [15:0] adj;
    adj        = acc;
    adj[15:12] = bcd_adjust(acc[15:12]);
    adj[11:8]  = bcd_adjust(acc[11:8]);
    return {adj[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// seg7_glyph_decoder
// Combinational map from a 4-bit display code to an active-low
// seven-segment pattern {g,f,e,d,c,b,a}.
// Ports:
//   code    in  4  display code: 0-9, CODE_DASH, CODE_E, CODE_R, CODE_BLANK
//   pattern out 7  active-low segment pattern (unknown codes show blank)
module seg7_glyph_decoder
  import weather_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  // Glyph lookup
  always_comb begin
    pattern = GLYPH_BLANK;
    case (code)
      4'd0:       pattern = GLYPH_0;
      4'd1:       pattern = GLYPH_1;
      4'd2:       pattern = GLYPH_2;
      4'd3:       pattern = GLYPH_3;
      4'd4:       pattern = GLYPH_4;
      4'd5:       pattern = GLYPH_5;
      4'd6:       pattern = GLYPH_6;
      4'd7:       pattern = GLYPH_7;
      4'd8:       pattern = GLYPH_8;
      4'd9:       pattern = GLYPH_9;
      CODE_DASH:  pattern = GLYPH_DASH;
      CODE_E:     pattern = GLYPH_E;
      CODE_R:     pattern = GLYPH_R;
      CODE_BLANK: pattern = GLYPH_BLANK;
      default:    pattern = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/weather_display_ctrl.sv
// weather_display_ctrl
// Captures DHT11 temperature/humidity readings, converts them to BCD with
// a sequential double-dabble engine and scans them onto a 4-digit
// common-anode seven-segment display (temperature left, humidity right).
//
// Optional feature macro: STALE_TIMEOUT_EN -- when defined, the display
// reverts to dashes and valid_out drops once STALE_MS milliseconds pass
// without a new reading being loaded.
//
// Ports:
//   clk_in           in  1  system clock
//   rst_in           in  1  synchronous active-high reset
//   temperature_in   in  8  integer degC, 8'hFF = sensor error
//   humidity_in      in  8  integer %RH, 8'hFF = sensor error
//   transfer_done_in in  1  one-cycle pulse qualifying the inputs
//   seg_out          out 7  active-low segments {g,f,e,d,c,b,a}
//   an_out           out 4  active-low anodes, an_out[3] = leftmost digit
//   dp_out           out 1  active-low decimal point, held off
//   valid_out        out 1  a reading is currently displayed
module weather_display_ctrl
  import weather_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned DIGIT_HZ = 1000,
  parameter int unsigned STALE_MS = 3000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] temperature_in,
  input  logic [7:0] humidity_in,
  input  logic       transfer_done_in,
  output logic [6:0] seg_out,
  output logic [3:0] an_out,
  output logic       dp_out,
  output logic       valid_out
);

  localparam int unsigned REFRESH_DIV = CLK_HZ / DIGIT_HZ;
  localparam int unsigned REFRESH_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);

  // Conversion path
  logic [1:0]  state_r;
  logic [3:0]  iter_r;
  logic [7:0]  temp_sh_r;
  logic [7:0]  hum_sh_r;
  logic [7:0]  q_temp_r;
  logic [7:0]  q_hum_r;
  logic        pending_r;
  logic [15:0] t_dd_r;
  logic [15:0] h_dd_r;
  logic        t_err_r;
  logic        h_err_r;
  logic        load_s;
  logic        stale_hit_s;

  // Display and scan path
  logic [3:0]     disp_r [4];
  logic           valid_r;
  logic [REFRESH_W-1:0] refresh_cnt_r;
  digit_sel_e     idx_r;
  logic           scan_on_r;
  logic [3:0]     code_mux_s;
  logic [6:0]     glyph_s;
  logic [3:0]     an_sel_s;
  logic [6:0]     seg_r;
  logic [3:0]     an_r;
  logic           dp_r;

  // LOAD is the single cycle in which the display registers take new digits
  always_comb begin
    if (state_r == ST_LOAD) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // Capture, queueing and double-dabble sequencing.
  // CONV step 0 loads the (saturated) shadows into the shifters; steps 1-8
  // are the eight dabble iterations, so the display updates at N+10.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r   <= ST_IDLE;
      iter_r    <= 4'd0;
      temp_sh_r <= 8'd0;
      hum_sh_r  <= 8'd0;
      q_temp_r  <= 8'd0;
      q_hum_r   <= 8'd0;
      pending_r <= 1'b0;
      t_dd_r    <= 16'd0;
      h_dd_r    <= 16'd0;
      t_err_r   <= 1'b0;
      h_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pending_r) begin
            // Queued reading goes first; a simultaneous pulse becomes the new queue entry
            temp_sh_r <= q_temp_r;
            hum_sh_r  <= q_hum_r;
            state_r   <= ST_CONV;
            iter_r    <= 4'd0;
            pending_r <= transfer_done_in;
            if (transfer_done_in) begin
              q_temp_r <= temperature_in;
              q_hum_r  <= humidity_in;
            end
          end else if (transfer_done_in) begin
            temp_sh_r <= temperature_in;
            hum_sh_r  <= humidity_in;
            state_r   <= ST_CONV;
            iter_r    <= 4'd0;
          end
        end
        ST_CONV: begin
          if (iter_r == 4'd0) begin
            t_dd_r  <= {8'd0, saturate(temp_sh_r)};
            h_dd_r  <= {8'd0, saturate(hum_sh_r)};
            t_err_r <= (temp_sh_r == ERR_CODE);
            h_err_r <= (hum_sh_r == ERR_CODE);
          end else begin
            t_dd_r <= dd_step(t_dd_r);
            h_dd_r <= dd_step(h_dd_r);
          end
          if (iter_r == 4'd8) begin
            state_r <= ST_LOAD;
          end
          iter_r <= iter_r + 4'd1;
          if (transfer_done_in) begin
            q_temp_r  <= temperature_in;
            q_hum_r   <= humidity_in;
            pending_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_r <= ST_IDLE;
          if (transfer_done_in) begin
            q_temp_r  <= temperature_in;
            q_hum_r   <= humidity_in;
            pending_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef STALE_TIMEOUT_EN
  localparam int unsigned TICKS_PER_MS = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int unsigned MS_W  = (STALE_MS > 1) ? $clog2(STALE_MS + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MS - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(STALE_MS - 1);

  logic [PRE_W-1:0] ms_pre_r;
  logic [MS_W-1:0]  ms_cnt_r;
  logic             stale_run_r;

  // Timeout fires on the tick that would bring the ms count to STALE_MS
  always_comb begin
    if (stale_run_r && (ms_pre_r == PRE_LAST) && (ms_cnt_r == MS_LAST)) begin
      stale_hit_s = 1'b1;
    end else begin
      stale_hit_s = 1'b0;
    end
  end

  // Millisecond age counter: restarted by LOAD, frozen after a timeout
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ms_pre_r    <= '0;
      ms_cnt_r    <= '0;
      stale_run_r <= 1'b0;
    end else if (load_s) begin
      ms_pre_r    <= '0;
      ms_cnt_r    <= '0;
      stale_run_r <= 1'b1;
    end else if (stale_hit_s) begin
      ms_pre_r    <= '0;
      ms_cnt_r    <= '0;
      stale_run_r <= 1'b0;
    end else if (stale_run_r) begin
      if (ms_pre_r == PRE_LAST) begin
        ms_pre_r <= '0;
        ms_cnt_r <= ms_cnt_r + MS_W'(1);
      end else begin
        ms_pre_r <= ms_pre_r + PRE_W'(1);
      end
    end
  end
`else
  // Readings are held indefinitely
  assign stale_hit_s = 1'b0;
`endif

  // Display registers: new digits on LOAD, dashes on reset or timeout
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 4; i++) begin
        disp_r[i] <= CODE_DASH;
      end
      valid_r <= 1'b0;
    end else if (load_s) begin
      disp_r[0] <= t_err_r ? CODE_E : t_dd_r[15:12];
      disp_r[1] <= t_err_r ? CODE_R : t_dd_r[11:8];
      disp_r[2] <= h_err_r ? CODE_E : h_dd_r[15:12];
      disp_r[3] <= h_err_r ? CODE_R : h_dd_r[11:8];
      valid_r   <= 1'b1;
    end else if (stale_hit_s) begin
      for (int i = 0; i < 4; i++) begin
        disp_r[i] <= CODE_DASH;
      end
      valid_r <= 1'b0;
    end
  end

  // Refresh divider and digit index; scanning starts at the first wrap
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      refresh_cnt_r <= '0;
      idx_r         <= DIG_T_TENS;
      scan_on_r     <= 1'b0;
    end else if (refresh_cnt_r == REFRESH_LAST) begin
      refresh_cnt_r <= '0;
      idx_r         <= digit_sel_e'(idx_r + 2'd1);
      scan_on_r     <= 1'b1;
    end else begin
      refresh_cnt_r <= refresh_cnt_r + REFRESH_W'(1);
    end
  end

  // Anode pattern for the current index (index i pulls an_out[3-i] low)
  always_comb begin
    an_sel_s = 4'b1111;
    case (idx_r)
      DIG_T_TENS: an_sel_s = 4'b0111;
      DIG_T_ONES: an_sel_s = 4'b1011;
      DIG_H_TENS: an_sel_s = 4'b1101;
      DIG_H_ONES: an_sel_s = 4'b1110;
      default:    an_sel_s = 4'b1111;
    endcase
  end

  assign code_mux_s = disp_r[idx_r];

  seg7_glyph_decoder u_glyph (
    .code    (code_mux_s),
    .pattern (glyph_s)
  );

  // Output registers: anode and glyph are registered together
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      seg_r <= GLYPH_BLANK;
      an_r  <= 4'hF;
      dp_r  <= 1'b1;
    end else if (scan_on_r) begin
      seg_r <= glyph_s;
      an_r  <= an_sel_s;
      dp_r  <= 1'b1;
    end else begin
      seg_r <= GLYPH_BLANK;
      an_r  <= 4'hF;
      dp_r  <= 1'b1;
    end
  end

  assign seg_out   = seg_r;
  assign an_out    = an_r;
  assign dp_out    = dp_r;
  assign valid_out = valid_r;

endmodule

// File: tb/tb_weather_display_ctrl.sv
// tb_weather_display_ctrl
// Table-driven self-checking bench for weather_display_ctrl with a
// scoreboard queue of expected display contents. Runs the DUT at
// CLK_HZ=10_000, DIGIT_HZ=5_000 (2 cycles per digit) and STALE_MS=2.
module tb_weather_display_ctrl;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GD = 7'b0111111;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GR = 7'b0101111;

  typedef struct packed {
    logic [27:0] glyphs;  // [27:21] leftmost digit ... [6:0] rightmost
    logic        valid;
  } exp_t;

  typedef struct packed {
    logic [7:0]  temp;
    logic [7:0]  hum;
    logic [27:0] glyphs;
  } vec_t;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] temperature_in = 8'd0;
  logic [7:0] humidity_in = 8'd0;
  logic       transfer_done_in = 1'b0;
  logic [6:0] seg_out;
  logic [3:0] an_out;
  logic       dp_out;
  logic       valid_out;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  vec_t vecs[9];

  weather_display_ctrl #(
    .CLK_HZ   (10_000),
    .DIGIT_HZ (5_000),
    .STALE_MS (2)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .temperature_in   (temperature_in),
    .humidity_in      (humidity_in),
    .transfer_done_in (transfer_done_in),
    .seg_out          (seg_out),
    .an_out           (an_out),
    .dp_out           (dp_out),
    .valid_out        (valid_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge, returning at the following falling edge
  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Drive a one-cycle done pulse; returns just after capture edge N
  task automatic pulse(input logic [7:0] t, input logic [7:0] h, input logic [27:0] g);
    exp_t e;
    temperature_in   = t;
    humidity_in      = h;
    transfer_done_in = 1'b1;
    tick();
    transfer_done_in = 1'b0;
    e.glyphs = g;
    e.valid  = 1'b1;
    sb_q.push_back(e);
  endtask

  function automatic int digit_of(input logic [3:0] an);
    case (an)
      4'b0111: return 0;
      4'b1011: return 1;
      4'b1101: return 2;
      4'b1110: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [6:0] glyph_at(input logic [27:0] g, input int d);
    case (d)
      0:       return g[27:21];
      1:       return g[20:14];
      2:       return g[13:7];
      default: return g[6:0];
    endcase
  endfunction

  // Pop the next expected display and check every scanned digit for ncyc cycles
  task automatic check_frame(input int ncyc, input string tag);
    exp_t       e;
    logic [3:0] seen;
    logic [3:0] prev;
    int         d;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_queue: got empty scoreboard expected an entry", tag);
      return;
    end
    e    = sb_q.pop_front();
    seen = 4'h0;
    prev = 4'hF;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      chk({tag, "_valid"}, 32'(valid_out), 32'(e.valid));
      chk({tag, "_dp"}, 32'(dp_out), 32'd1);
      if (an_out != 4'hF) begin
        chk({tag, "_onehot"}, 32'($countones(~an_out)), 32'd1);
        d = digit_of(an_out);
        if (d >= 0) begin
          seen[d] = 1'b1;
          chk({tag, "_seg"}, 32'(seg_out), 32'(glyph_at(e.glyphs, d)));
        end
        if ((prev != 4'hF) && (an_out != prev)) begin
          chk({tag, "_scan"}, 32'(an_out), 32'({prev[0], prev[3:1]}));
        end
        prev = an_out;
      end else begin
        chk({tag, "_blank"}, 32'(seg_out), 32'h7F);
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'hF);
  endtask

  task automatic push_dashes();
    exp_t e;
    e.glyphs = {GD, GD, GD, GD};
    e.valid  = 1'b0;
    sb_q.push_back(e);
  endtask

  initial begin
    vecs[0] = '{temp: 8'd25,  hum: 8'd60,  glyphs: {G2, G5, G6, G0}};
    vecs[1] = '{temp: 8'hFF,  hum: 8'd45,  glyphs: {GE, GR, G4, G5}};
    vecs[2] = '{temp: 8'd150, hum: 8'd3,   glyphs: {G9, G9, G0, G3}};
    vecs[3] = '{temp: 8'd7,   hum: 8'd0,   glyphs: {G0, G7, G0, G0}};
    vecs[4] = '{temp: 8'd100, hum: 8'd99,  glyphs: {G9, G9, G9, G9}};
    vecs[5] = '{temp: 8'd0,   hum: 8'hFF,  glyphs: {G0, G0, GE, GR}};
    vecs[6] = '{temp: 8'hFF,  hum: 8'hFF,  glyphs: {GE, GR, GE, GR}};
    vecs[7] = '{temp: 8'd254, hum: 8'd18,  glyphs: {G9, G9, G1, G8}};
    vecs[8] = '{temp: 8'd38,  hum: 8'd71,  glyphs: {G3, G8, G7, G1}};

    // Reset held for three edges, then dashes over four refresh frames
    rst_in = 1'b1;
    @(negedge clk_in);
    tick();
    tick();
    tick();
    chk("rst_seg", 32'(seg_out), 32'h7F);
    chk("rst_an", 32'(an_out), 32'hF);
    chk("rst_dp", 32'(dp_out), 32'd1);
    chk("rst_valid", 32'(valid_out), 32'd0);
    rst_in = 1'b0;
    push_dashes();
    check_frame(34, "rst_frame");

    // Table of single readings
    for (int i = 0; i < 9; i++) begin
      pulse(vecs[i].temp, vecs[i].hum, vecs[i].glyphs);
      for (int k = 1; k <= 9; k++) tick();
      if (i == 0) chk("lat_n9_valid", 32'(valid_out), 32'd0);
      tick();
      chk("lat_n10_valid", 32'(valid_out), 32'd1);
      check_frame(10, "vec");
    end

    // Pulse during conversion is queued and converted afterwards
    pulse(8'd20, 8'd30, {G2, G0, G3, G0});
    tick();
    tick();
    tick();
    pulse(8'd21, 8'd31, {G2, G1, G3, G1});
    for (int k = 5; k <= 10; k++) tick();
    chk("pend_n10_valid", 32'(valid_out), 32'd1);
    check_frame(10, "pend_first");
    tick();
    check_frame(10, "pend_second");

    // Reset mid-conversion abandons it and restores dashes
    pulse(8'd55, 8'd66, {G5, G5, G6, G6});
    void'(sb_q.pop_back());
    tick();
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    push_dashes();
    check_frame(14, "midrst");

`ifdef STALE_TIMEOUT_EN
    // Timeout: dashes exactly 20 cycles after LOAD, restored by a new pulse
    pulse(8'd42, 8'd57, {G4, G2, G5, G7});
    for (int k = 1; k <= 10; k++) tick();
    chk("stale_load_valid", 32'(valid_out), 32'd1);
    void'(sb_q.pop_front());
    for (int k = 1; k <= 19; k++) tick();
    chk("stale_l19_valid", 32'(valid_out), 32'd1);
    tick();
    chk("stale_l20_valid", 32'(valid_out), 32'd0);
    push_dashes();
    check_frame(10, "stale_dash");
    pulse(8'd42, 8'd57, {G4, G2, G5, G7});
    for (int k = 1; k <= 10; k++) tick();
    check_frame(10, "stale_restore");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
